// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: credit-limited sequential fetch into an
// in-order {instr, pc} queue, with redirect flush of in-flight responses.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;

  logic [CW-1:0] count, outstanding, drop_cnt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   fetch_pc, resp_pc;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic [SW-1:0] occ, inflt, redir_drop;
  logic [31:0]   target;
  logic          issue, pop, drop, push, orphan;

  assign occ   = SW'(count) + SW'(outstanding);
  assign inflt = SW'(outstanding) + SW'(drop_cnt);

  assign mem_req  = !reset && !redirect_valid &&
                    (occ < SW'(DEPTH)) && (inflt < SW'(DEPTH));
  assign mem_addr = fetch_pc;

  assign issue  = mem_req && mem_gnt;
  assign drop   = mem_rvalid && (drop_cnt != '0);
  assign push   = mem_rvalid && (drop_cnt == '0) && (outstanding != '0);
  assign orphan = mem_rvalid && (drop_cnt == '0) && (outstanding == '0);
  assign pop    = if_valid && if_ready;

  // A response in the redirect cycle belongs to the old stream.
  assign redir_drop = inflt - SW'(mem_rvalid && (inflt != '0));
  assign target     = redirect_pc & ~32'h3;

  assign if_valid = (count != '0);
  assign if_instr = if_valid ? q_instr[rd_ptr] : '0;
  assign if_pc    = if_valid ? q_pc[rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      q_instr[wr_ptr] <= mem_rdata;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (orphan)
        proto_err <= 1'b1;
      if (redirect_valid) begin
        fetch_pc    <= target;
        resp_pc     <= target;
        count       <= '0;
        outstanding <= '0;
        drop_cnt    <= CW'(redir_drop);
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        if (issue)
          fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + 1'b1;
        end
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (drop)
          drop_cnt <= drop_cnt - 1'b1;
        outstanding <= outstanding + CW'(issue) - CW'(push);
        count       <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Random-latency memory and pipeline drain against a queue-level
// reference model of the fetch stream.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, reset;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        proto_err;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // reference model: expected queue contents and memory in-flight list
  logic [31:0] exp_fetch;
  logic [31:0] exp_q [$];
  logic [31:0] fl_addr [$];
  int          fl_due [$];
  bit          fl_stale [$];
  bit          exp_proto;
  int          cyc, pops, grants, first_valid;
  bit          watch;
  logic [31:0] first_after;

  int gnt_pct, lat_min, lat_max, rdy_pct, redir_pct;
  int force_mode;
  logic [31:0] force_pc;
  bit inject;

  task automatic step();
    bit rv, rd, g, rdy, forced, ereq, s;
    logic [31:0] rpc, a;
    int live, stale, d;
    rv = (fl_addr.size() > 0) && (fl_due[0] <= cyc);
    forced = (force_mode == 1) || (force_mode == 2 && rv);
    rd = forced || ($urandom_range(99) < redir_pct);
    if (forced) rpc = force_pc;
    else if ($urandom_range(7) == 0) rpc = 32'hFFFF_FFF0 | $urandom_range(15);
    else rpc = $urandom;
    if (forced) begin
      force_mode = 0;
      watch = 1;
    end
    g   = $urandom_range(99) < gnt_pct;
    rdy = $urandom_range(99) < rdy_pct;
    mem_rvalid     = rv || inject;
    mem_rdata      = rv ? mem_word(fl_addr[0]) : 32'hDEAD_BEEF;
    mem_gnt        = g;
    if_ready       = rdy;
    redirect_valid = rd;
    redirect_pc    = rpc;
    #1;
    live = 0;
    stale = 0;
    foreach (fl_stale[i]) if (fl_stale[i]) stale++; else live++;
    ereq = !rd && (exp_q.size() + live < DEPTH) && (fl_addr.size() < DEPTH);
    check("mem_req", mem_req, ereq);
    if (ereq) check("mem_addr", mem_addr, exp_fetch);
    check("if_valid", if_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("if_pc", if_pc, exp_q[0]);
      check("if_instr", if_instr, mem_word(exp_q[0]));
    end
    check("proto_err", proto_err, exp_proto);
    if (if_valid && first_valid < 0) first_valid = cyc;
    if (exp_q.size() != 0 && rdy && !rd) begin
      if (watch) begin
        first_after = exp_q[0];
        watch = 0;
      end
      void'(exp_q.pop_front());
      pops++;
    end
    if (rv) begin
      a = fl_addr.pop_front();
      d = fl_due.pop_front();
      s = fl_stale.pop_front();
      if (!s && !rd) exp_q.push_back(a);
    end else if (inject) begin
      exp_proto = 1;
    end
    inject = 0;
    if (rd) begin
      exp_q.delete();
      foreach (fl_stale[i]) fl_stale[i] = 1;
      exp_fetch = rpc & ~32'h3;
    end
    if (ereq && g) begin
      fl_addr.push_back(exp_fetch);
      fl_due.push_back(cyc + 1 + $urandom_range(lat_max, lat_min));
      fl_stale.push_back(0);
      exp_fetch += 32'd4;
      grants++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    mem_gnt = 0;
    mem_rvalid = 0;
    mem_rdata = '0;
    if_ready = 0;
    redirect_valid = 0;
    redirect_pc = '0;
    reset = 1;
    #1;
    exp_q.delete();
    fl_addr.delete();
    fl_due.delete();
    fl_stale.delete();
    exp_proto = 0;
    check("rst_mem_req", mem_req, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_proto_err", proto_err, 0);
    @(negedge clk);
    reset = 0;
    exp_fetch = RST_PC;
    cyc = 0;
    pops = 0;
    grants = 0;
    first_valid = -1;
    watch = 0;
    first_after = 32'hFFFF_FFFF;
  endtask

  task automatic knobs(int g, int lmin, int lmax, int r, int rd);
    gnt_pct = g;
    lat_min = lmin;
    lat_max = lmax;
    rdy_pct = r;
    redir_pct = rd;
  endtask

  initial begin
    force_mode = 0;
    inject = 0;
    reset = 1;

    // zero-wait memory, always ready
    knobs(100, 0, 0, 100, 0);
    do_reset();
    run(10);
    check("first_valid_cyc", first_valid, 2);
    check("zero_wait_pops", pops, 8);

    // pipeline stall fills exactly DEPTH credits
    knobs(100, 0, 0, 0, 0);
    do_reset();
    run(20);
    check("stall_grants", grants, DEPTH);
    check("stall_mem_req", mem_req, 0);
    check("stall_if_valid", if_valid, 1);
    rdy_pct = 100;
    run(20);
    check("stall_resume", pops >= 5, 1);

    // redirect with requests in flight
    knobs(100, 3, 3, 100, 0);
    do_reset();
    run(3);
    force_mode = 1;
    force_pc = 32'h0000_0103;
    run(25);
    check("redir_first_pc", first_after, 32'h0000_0100);

    // redirect coinciding with a response
    knobs(100, 2, 2, 100, 0);
    do_reset();
    run(3);
    force_mode = 2;
    force_pc = 32'h0000_0200;
    run(25);
    check("redir_rv_first_pc", first_after, 32'h0000_0200);

    // random latency, grant, drain and redirects
    knobs(60, 0, 5, 70, 2);
    do_reset();
    while (pops < 1000 && cyc < 30000) step();
    check("random_pops", pops >= 1000, 1);

    // orphan response with a full queue, then reset mid-stream
    knobs(100, 0, 0, 0, 0);
    do_reset();
    run(10);
    check("drained", fl_addr.size(), 0);
    gnt_pct = 0;
    inject = 1;
    run(1);
    run(5);
    check("proto_sticky", proto_err, 1);
    check("proto_q_hold", if_valid, 1);
    knobs(60, 0, 5, 70, 0);
    run(10);
    do_reset();
    knobs(100, 0, 2, 80, 0);
    run(20);
    check("restart_grants", grants > 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
